proc_control_unit: RTL
======================

// Module: proc_control_unit
// PURPOSE
//  Moore FSM that sequences the ProjectB processor datapath.
//  - Drives the 7-bit PC counter (clear/up) and the instruction register load.
//  - Decodes the 16-bit instruction and issues data-memory, register-file and ALU controls.
//  - Sits between instruction memory/IR and the datapath; one instruction in flight at a time.
// PARAMETERS
//  IR_W      16  instruction width; opcode = ir[15:12]
//  D_ADDR_W   8  data-memory address width
//  RF_ADDR_W  4  register-file address width
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; forces INIT
//  ir         in   16  current instruction from IR
//  pc_clr     out  1   PC counter synchronous clear
//  pc_up      out  1   PC counter increment
//  ir_ld      out  1   IR load enable
//  d_addr     out  8   data-memory address
//  d_wr       out  1   data-memory write enable
//  rf_s       out  1   RF write-data mux: 1 = memory, 0 = ALU
//  rf_w_addr  out  4   RF write address
//  rf_w_wr    out  1   RF write enable
//  rf_ra_addr out  4   RF read port A address
//  rf_ra_rd   out  1   RF read port A enable
//  rf_rb_addr out  4   RF read port B address
//  rf_rb_rd   out  1   RF read port B enable
//  alu_s      out  3   ALU select: 000 pass, 001 add, 010 sub
//  state      out  4   current state code, for display/debug
//  halted     out  1   high while in HALT
// BEHAVIOUR
//  - State register is the only storage: async reset, otherwise updates on posedge clk.
//  - All outputs decode combinationally from state and ir fields.
//  - Outputs not listed for a state are 0 in that state.
//  - While reset is high: state=INIT and all outputs equal their INIT values.
//  - Encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6,
//    ADD=7, SUB=8, HALT=9.
//  - Opcodes: NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5.
//  - Opcodes 6..15 are treated as NOOP: no writes, no PC change.
//  - Fields:
//    - LOAD:    d_addr=ir[11:4], rf_w_addr=ir[3:0]
//    - STORE:   rf_ra_addr=ir[11:8], d_addr=ir[7:0]
//    - ADD/SUB: ra=ir[11:8], rb=ir[7:4], w=ir[3:0]
//  - Address outputs always present the decoded fields, regardless of state.
//  - Per-state outputs and transitions:
//    - INIT: pc_clr=1 -> FETCH.
//    - FETCH: ir_ld=1, pc_up=1 -> DECODE.
//      - Instruction memory output must be valid for the current PC during FETCH.
//      - IR is valid from DECODE onward.
//    - DECODE: no strobes -> state selected by ir[15:12].
//    - NOOP -> FETCH.
//    - LOAD_A: rf_s=1 (memory read cycle) -> LOAD_B.
//    - LOAD_B: rf_s=1, rf_w_wr=1 -> FETCH.
//    - STORE: rf_ra_rd=1, d_wr=1 -> FETCH.
//    - ADD: rf_ra_rd=1, rf_rb_rd=1, rf_w_wr=1, alu_s=001 -> FETCH.
//    - SUB: as ADD, with alu_s=010.
//    - HALT: halted=1; stays in HALT until reset; pc_up, d_wr and rf_w_wr stay 0.
//  - Latency, FETCH to next FETCH:
//    - 3 cycles for NOOP/STORE/ADD/SUB.
//    - 4 cycles for LOAD.
//  - PC wrap 127->0 belongs to the counter. The FSM does nothing special at wrap.
//  - Write strobes are never asserted in INIT, FETCH or DECODE.
//  - Reset mid-instruction: the instruction is abandoned in the same cycle, with no write
//    strobe after reset assertion. On release: INIT, then FETCH from PC=0.
//  - Illegal or unreachable state encodings -> INIT on the next edge.
// STRUCTURE
//  - proc_ctrl_pkg: state_t enum, opcode localparams, alu_s constants, field-slice widths.
//  - Sub-module ir_field_decode (combinational): splits ir into opcode/ra/rb/rw/d_addr.
//  - FSM (next-state and output always_comb blocks) stays in proc_control_unit.
// TESTING
//  1. Assert reset 2 cycles, release.
//     -> state=0 with pc_clr=1 for 1 cycle; then FETCH with ir_ld=1, pc_up=1.
//  2. ir=16'h3123.
//     -> ADD state: ra=1, rb=2, w=3, alu_s=001, rf_w_wr=1; next state FETCH.
//     Repeat with 16'h4123 -> SUB, alu_s=010.
//  3. ir=16'h21A5.
//     -> LOAD_A: d_addr=8'h1A, rf_s=1, rf_w_wr=0.
//     -> LOAD_B: rf_w_wr=1, rf_w_addr=5. FETCH follows 4 cycles after the prior FETCH.
//  4. ir=16'h1405.
//     -> STORE: d_addr=8'h05, ra=4, d_wr=1, rf_w_wr=0.
//     ir=16'hF000 -> NOOP, all write strobes 0.
//  5. ir=16'h5000.
//     -> HALT with halted=1 held for 10 cycles; pc_up never asserted.
//  6. Assert reset mid-LOAD_A, between clock edges.
//     -> state=INIT immediately; no rf_w_wr pulse; clean restart through FETCH.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the ProjectB processor control unit.
package proc_ctrl_pkg;
  localparam int IR_W      = 16;
  localparam int D_ADDR_W  = 8;
  localparam int RF_ADDR_W = 4;
  localparam int OPC_W     = 4;
  localparam int STATE_W   = 4;
  localparam int ALU_S_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'd5;

  localparam logic [ALU_S_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_S_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_S_W-1:0] ALU_SUB  = 3'b010;
endpackage

// File: rtl/ir_field_decode.sv
// Splits the instruction word into opcode, register and data-address fields.
module ir_field_decode
  import proc_ctrl_pkg::*;
(
  input  logic [IR_W-1:0]      ir,
  output logic [OPC_W-1:0]     opcode,
  output logic [RF_ADDR_W-1:0] ra,
  output logic [RF_ADDR_W-1:0] rb,
  output logic [RF_ADDR_W-1:0] rw,
  output logic [D_ADDR_W-1:0]  d_addr
);
  assign opcode = ir[15:12];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rw     = ir[3:0];

  // STORE carries its memory address in the low byte; every other format
  // (LOAD in particular) carries it in ir[11:4].
  always_comb begin
    d_addr = ir[11:4];
    if (opcode == OP_STORE) d_addr = ir[7:0];
  end
endmodule

// File: rtl/proc_control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the ProjectB datapath.
module proc_control_unit
  import proc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        ir_ld,
  output logic [7:0]  d_addr,
  output logic        d_wr,
  output logic        rf_s,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_wr,
  output logic [3:0]  rf_ra_addr,
  output logic        rf_ra_rd,
  output logic [3:0]  rf_rb_addr,
  output logic        rf_rb_rd,
  output logic [2:0]  alu_s,
  output logic [3:0]  state,
  output logic        halted
);
  state_t           state_q, state_d;
  logic [OPC_W-1:0] opcode;

  ir_field_decode u_dec (
    .ir     (ir),
    .opcode (opcode),
    .ra     (rf_ra_addr),
    .rb     (rf_rb_addr),
    .rw     (rf_w_addr),
    .d_addr (d_addr)
  );

  assign state = state_q;

  // State register: the only storage in the block; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Next-state: straight-line sequencing, dispatch on opcode in DECODE.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;  // 0 and unused opcodes 6..15
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;      // illegal encodings recover via INIT
    endcase
  end

  // Output decode: strobes depend only on the current state.
  always_comb begin
    pc_clr   = 1'b0;
    pc_up    = 1'b0;
    ir_ld    = 1'b0;
    d_wr     = 1'b0;
    rf_s     = 1'b0;
    rf_w_wr  = 1'b0;
    rf_ra_rd = 1'b0;
    rf_rb_rd = 1'b0;
    alu_s    = ALU_PASS;
    halted   = 1'b0;
    case (state_q)
      S_INIT:   pc_clr = 1'b1;
      S_FETCH:  begin ir_ld = 1'b1; pc_up = 1'b1; end
      S_LOAD_A: rf_s = 1'b1;  // memory read cycle, mux pre-selected
      S_LOAD_B: begin rf_s = 1'b1; rf_w_wr = 1'b1; end
      S_STORE:  begin rf_ra_rd = 1'b1; d_wr = 1'b1; end
      S_ADD:    begin rf_ra_rd = 1'b1; rf_rb_rd = 1'b1; rf_w_wr = 1'b1; alu_s = ALU_ADD; end
      S_SUB:    begin rf_ra_rd = 1'b1; rf_rb_rd = 1'b1; rf_w_wr = 1'b1; alu_s = ALU_SUB; end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end
endmodule
